irrigacao_multizona: RTL and testbench

- Clocked, N-zone successor to the single-zone combinational irrigation controller.
- Synchronises and debounces the shared water-tank level sensors, then derives Erro, Alarme and ValvulaEntrada.
- Runs one irrigation FSM per zone, granting at most one active zone at a time by round-robin, with a run-time limit and a rest period.
- Time-multiplexes a single 7-segment display between tank level and irrigation type.

---
 rtl/irrigacao_multizona_if.sv | 40 ++++
 rtl/irrigacao_multizona.sv | 221 ++++++++++++++++++++++
 tb/tb_irrigacao_multizona.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irrigacao_multizona_if.sv
// Signal bundle between the multi-zone irrigation controller and its environment.
// Clock and reset stay outside the bundle as plain ports.
interface irrigacao_multizona_if #(
    parameter int unsigned NUM_ZONES = 4
);
    localparam int unsigned ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

    logic [NUM_ZONES-1:0] UmidadeSolo;
    logic [NUM_ZONES-1:0] UmidadeAr;
    logic [NUM_ZONES-1:0] Temperatura;
    logic                 High;
    logic                 Medium;
    logic                 Low;
    logic                 ModoDisplay;
    logic                 ChaveSeletora;
    logic [NUM_ZONES-1:0] Gotejamento;
    logic [NUM_ZONES-1:0] Aspersao;
    logic                 Erro;
    logic                 Alarme;
    logic                 ValvulaEntrada;
    logic [ZW-1:0]        ZonaAtiva;
    logic [6:0]           Segmentos;
    logic                 FaseDisplay;

    // Environment side: drives sensors and display controls.
    modport master (
        output UmidadeSolo, UmidadeAr, Temperatura, High, Medium, Low,
        output ModoDisplay, ChaveSeletora,
        input  Gotejamento, Aspersao, Erro, Alarme, ValvulaEntrada,
        input  ZonaAtiva, Segmentos, FaseDisplay
    );

    // Controller side.
    modport slave (
        input  UmidadeSolo, UmidadeAr, Temperatura, High, Medium, Low,
        input  ModoDisplay, ChaveSeletora,
        output Gotejamento, Aspersao, Erro, Alarme, ValvulaEntrada,
        output ZonaAtiva, Segmentos, FaseDisplay
    );
endinterface

// File: rtl/irrigacao_multizona.sv
// Multi-zone irrigation controller: synchronised and debounced tank sensors,
// one irrigation FSM per zone with a round-robin single-active-zone arbiter,
// and a time-multiplexed 7-segment display.
module irrigacao_multizona #(
    parameter int unsigned NUM_ZONES       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned MAX_RUN         = 200,
    parameter int unsigned PAUSE_CYCLES    = 50,
    parameter int unsigned DISPLAY_DIV     = 1000
) (
    input logic                   Clock,
    input logic                   Reset_n,
    irrigacao_multizona_if.slave  bus
);
    localparam int unsigned ZW   = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMAX = (MAX_RUN > PAUSE_CYCLES) ? MAX_RUN : PAUSE_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned VW   = $clog2(DISPLAY_DIV + 1);

    typedef enum logic [1:0] {Idle, Gotejar, Aspersar, Pausa} zoneState_t;

    logic [NUM_ZONES-1:0] soloMeta, soloSync, arMeta, arSync, tempMeta, tempSync;
    logic [2:0]           nivelMeta, nivelSync, nivelFilt;  // {High, Medium, Low}
    logic [DW-1:0]        debCnt [3];
    logic                 erro, alarme, valvula;
    logic                 hf, mf, lf, erroNow, alarmNow;
    logic [NUM_ZONES-1:0] dripReq, sprReq, grant, gotReg, aspReg;
    logic [ZW-1:0]        ptr, grantIdx, idx;
    zoneState_t           state [NUM_ZONES];
    logic [TW-1:0]        timer [NUM_ZONES];
    logic [VW-1:0]        divCnt;
    logic                 autoPhase, fase;
    logic [6:0]           tankCode, irrCode, seg;

    // Two-flop synchronisers for every asynchronous input.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            soloMeta  <= '0; soloSync  <= '0;
            arMeta    <= '0; arSync    <= '0;
            tempMeta  <= '0; tempSync  <= '0;
            nivelMeta <= '0; nivelSync <= '0;
        end else begin
            soloMeta  <= bus.UmidadeSolo;  soloSync  <= soloMeta;
            arMeta    <= bus.UmidadeAr;    arSync    <= arMeta;
            tempMeta  <= bus.Temperatura;  tempSync  <= tempMeta;
            nivelMeta <= {bus.High, bus.Medium, bus.Low};
            nivelSync <= nivelMeta;
        end
    end

    // Per-sensor debounce: accept a change only after it persists long enough.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            nivelFilt <= '0;
            for (int k = 0; k < 3; k++) debCnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (nivelSync[k] != nivelFilt[k]) begin
                    if (debCnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        nivelFilt[k] <= nivelSync[k];
                        debCnt[k]    <= '0;
                    end else begin
                        debCnt[k] <= debCnt[k] + 1'b1;
                    end
                end else begin
                    debCnt[k] <= '0;
                end
            end
        end
    end

    assign hf       = nivelFilt[2];
    assign mf       = nivelFilt[1];
    assign lf       = nivelFilt[0];
    assign erroNow  = (hf & ~mf) | (mf & ~lf);
    assign alarmNow = ~lf | erroNow;

    // Tank flags, one cycle behind the filtered levels.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            erro    <= 1'b0;
            alarme  <= 1'b0;
            valvula <= 1'b0;
        end else begin
            erro    <= erroNow;
            alarme  <= alarmNow;
            valvula <= ~erroNow & ~hf;
        end
    end

    // Zone demand; the two terms are mutually exclusive.
    assign dripReq = ~soloSync & arSync & ({NUM_ZONES{~mf}} | tempSync);
    assign sprReq  = ~soloSync & (~arSync | ({NUM_ZONES{mf}} & ~tempSync));

    // Round-robin arbiter. The filtered-level term keeps it shut right after
    // reset, before the registered Alarme has caught up with empty levels.
    always_comb begin
        grant    = '0;
        grantIdx = ptr;
        idx      = '0;
        if (((gotReg | aspReg) == '0) && !alarme && !alarmNow) begin
            for (int k = 1; k <= int'(NUM_ZONES); k++) begin
                idx = ZW'((int'(ptr) + k) % int'(NUM_ZONES));
                if ((grant == '0) && (state[idx] == Idle) && (dripReq[idx] | sprReq[idx])) begin
                    grant[idx] = 1'b1;
                    grantIdx   = idx;
                end
            end
        end
    end

    // Pointer doubles as the last-granted zone index.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr <= '0;
        end else if (grant != '0) begin
            ptr <= grantIdx;
        end
    end

    // Per-zone FSMs with registered valve outputs; Alarme aborts without pausing.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(NUM_ZONES); i++) begin
                state[i] <= Idle;
                timer[i] <= '0;
            end
            gotReg <= '0;
            aspReg <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_ZONES); i++) begin
                case (state[i])
                    Idle: begin
                        timer[i] <= '0;
                        if (grant[i] && dripReq[i]) begin
                            state[i]  <= Gotejar;
                            gotReg[i] <= 1'b1;
                        end else if (grant[i] && sprReq[i]) begin
                            state[i]  <= Aspersar;
                            aspReg[i] <= 1'b1;
                        end
                    end
                    Gotejar, Aspersar: begin
                        // A mode flip drops the latched request, so it ends the run.
                        if (alarme || ((state[i] == Gotejar) ? !dripReq[i] : !sprReq[i])) begin
                            state[i]  <= Idle;
                            timer[i]  <= '0;
                            gotReg[i] <= 1'b0;
                            aspReg[i] <= 1'b0;
                        end else if (timer[i] == TW'(MAX_RUN - 1)) begin
                            state[i]  <= Pausa;
                            timer[i]  <= '0;
                            gotReg[i] <= 1'b0;
                            aspReg[i] <= 1'b0;
                        end else begin
                            timer[i] <= timer[i] + 1'b1;
                        end
                    end
                    Pausa: begin
                        if (timer[i] == TW'(PAUSE_CYCLES - 1)) begin
                            state[i] <= Idle;
                            timer[i] <= '0;
                        end else begin
                            timer[i] <= timer[i] + 1'b1;
                        end
                    end
                    default: state[i] <= Idle;
                endcase
            end
        end
    end

    // Display phase divider; keeps running in manual mode.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            divCnt    <= '0;
            autoPhase <= 1'b0;
        end else if (divCnt == VW'(DISPLAY_DIV - 1)) begin
            divCnt    <= '0;
            autoPhase <= ~autoPhase;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    assign fase = bus.ModoDisplay ? bus.ChaveSeletora : autoPhase;

    // Segment codes for both display sources.
    always_comb begin
        tankCode = 7'h3F;
        if (erroNow) begin
            tankCode = 7'h79;
        end else begin
            case ({hf, mf, lf})
                3'b111:  tankCode = 7'h4F;
                3'b011:  tankCode = 7'h5B;
                3'b001:  tankCode = 7'h06;
                default: tankCode = 7'h3F;
            endcase
        end
        if (gotReg != '0)      irrCode = 7'h3D;
        else if (aspReg != '0) irrCode = 7'h77;
        else                   irrCode = 7'h40;
    end

    // Registered segment drive.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) seg <= 7'h00;
        else          seg <= fase ? irrCode : tankCode;
    end

    assign bus.Gotejamento    = gotReg;
    assign bus.Aspersao       = aspReg;
    assign bus.Erro           = erro;
    assign bus.Alarme         = alarme;
    assign bus.ValvulaEntrada = valvula;
    assign bus.ZonaAtiva      = ptr;
    assign bus.Segmentos      = seg;
    assign bus.FaseDisplay    = fase;
endmodule

// File: tb/tb_irrigacao_multizona.sv
// Directed bench for irrigacao_multizona with a queue of expected values.
module tb_irrigacao_multizona;
    localparam int unsigned NZ = 4;

    logic Clock = 1'b0;
    logic Reset_n;
    always #5 Clock = ~Clock;

    irrigacao_multizona_if #(.NUM_ZONES(NZ)) bus ();

    irrigacao_multizona #(
        .NUM_ZONES      (NZ),
        .DEBOUNCE_CYCLES(8),
        .MAX_RUN        (200),
        .PAUSE_CYCLES   (50),
        .DISPLAY_DIV    (1000)
    ) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic expectVal(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic checkVal(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0h required none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Cycles a valve stays high (bounded).
    task automatic measureHigh(input int zone, input bit spr, output int len);
        len = 0;
        while (((spr ? bus.Aspersao[zone] : bus.Gotejamento[zone]) === 1'b1) && len < 400) begin
            tick(1);
            len++;
        end
    endtask

    // Cycles a valve stays low (bounded).
    task automatic measureLow(input int zone, input bit spr, output int len);
        len = 0;
        while (((spr ? bus.Aspersao[zone] : bus.Gotejamento[zone]) !== 1'b1) && len < 400) begin
            tick(1);
            len++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  len;
        bit  sawAlarme;
        bit  sawDrop;

        Reset_n           = 1'b0;
        bus.UmidadeSolo   = '1;
        bus.UmidadeAr     = '0;
        bus.Temperatura   = '0;
        bus.High          = 1'b0;
        bus.Medium        = 1'b0;
        bus.Low           = 1'b0;
        bus.ModoDisplay   = 1'b1;
        bus.ChaveSeletora = 1'b0;
        tick(2);

        // Reset state.
        expectVal("rst_gotejamento", 0);  checkVal(32'(bus.Gotejamento));
        expectVal("rst_aspersao", 0);     checkVal(32'(bus.Aspersao));
        expectVal("rst_erro", 0);         checkVal(32'(bus.Erro));
        expectVal("rst_alarme", 0);       checkVal(32'(bus.Alarme));
        expectVal("rst_valvula", 0);      checkVal(32'(bus.ValvulaEntrada));
        expectVal("rst_zona", 0);         checkVal(32'(bus.ZonaAtiva));
        expectVal("rst_seg", 0);          checkVal(32'(bus.Segmentos));
        expectVal("rst_fase", 0);         checkVal(32'(bus.FaseDisplay));

        // Release with an empty tank.
        Reset_n = 1'b1;
        expectVal("empty_alarme", 1);
        expectVal("empty_valvula", 1);
        expectVal("empty_seg", 32'h3F);
        tick(1);
        checkVal(32'(bus.Alarme));
        checkVal(32'(bus.ValvulaEntrada));
        checkVal(32'(bus.Segmentos));

        // Fill: 2 sync + 8 debounce cycles to the filter, one more to the flags.
        bus.High = 1'b1; bus.Medium = 1'b1; bus.Low = 1'b1;
        expectVal("fill_alarme_early", 1);
        tick(10);
        checkVal(32'(bus.Alarme));
        expectVal("fill_alarme", 0);
        expectVal("fill_erro", 0);
        expectVal("fill_valvula", 0);
        expectVal("fill_seg", 32'h4F);
        tick(1);
        checkVal(32'(bus.Alarme));
        checkVal(32'(bus.Erro));
        checkVal(32'(bus.ValvulaEntrada));
        checkVal(32'(bus.Segmentos));

        // Run limit: zone 0 sprinkles (dry soil, dry air).
        bus.UmidadeSolo = 4'b1110;
        expectVal("run_pre", 0);
        expectVal("run_start", 4'b0001);
        expectVal("run_zona", 0);
        expectVal("run_len", 200);
        expectVal("run_gap", 51);  // 50 PAUSA cycles plus one IDLE cycle to regrant
        tick(2);
        checkVal(32'(bus.Aspersao));
        tick(1);
        checkVal(32'(bus.Aspersao));
        checkVal(32'(bus.ZonaAtiva));
        measureHigh(0, 1'b1, len);
        checkVal(32'(len));
        measureLow(0, 1'b1, len);
        checkVal(32'(len));

        // Glitch on Low shorter than the debounce window.
        expectVal("glitch_alarme", 0);
        expectVal("glitch_aspersao_kept", 0);
        sawAlarme = 1'b0;
        sawDrop   = 1'b0;
        bus.Low = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus.Alarme !== 1'b0) sawAlarme = 1'b1;
            if (bus.Aspersao[0] !== 1'b1) sawDrop = 1'b1;
        end
        bus.Low = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (bus.Alarme !== 1'b0) sawAlarme = 1'b1;
            if (bus.Aspersao[0] !== 1'b1) sawDrop = 1'b1;
        end
        checkVal(32'(sawAlarme));
        checkVal(32'(sawDrop));

        // Sustained Low=0 raises Alarme and aborts the active zone.
        bus.Low = 1'b0;
        expectVal("hold_alarme_early", 0);
        expectVal("hold_alarme", 1);
        expectVal("hold_erro", 1);
        expectVal("hold_drop", 0);
        tick(10);
        checkVal(32'(bus.Alarme));
        tick(1);
        checkVal(32'(bus.Alarme));
        checkVal(32'(bus.Erro));
        tick(1);
        checkVal(32'(bus.Aspersao));

        // Recover and stop zone 0's demand.
        bus.Low = 1'b1;
        expectVal("recover_alarme", 0);
        tick(11);
        checkVal(32'(bus.Alarme));
        bus.UmidadeSolo = '1;
        expectVal("quiet_aspersao", 0);
        tick(5);
        checkVal(32'(bus.Aspersao));

        // Inconsistent sensors: High without Medium.
        bus.Medium = 1'b0;
        expectVal("err_erro", 1);
        expectVal("err_alarme", 1);
        expectVal("err_valvula", 0);
        expectVal("err_seg", 32'h79);
        tick(11);
        checkVal(32'(bus.Erro));
        checkVal(32'(bus.Alarme));
        checkVal(32'(bus.ValvulaEntrada));
        checkVal(32'(bus.Segmentos));
        bus.Medium = 1'b1;
        expectVal("err_clear", 0);
        tick(11);
        checkVal(32'(bus.Erro));

        // Manual switch to the irrigation source.
        bus.ChaveSeletora = 1'b1;
        expectVal("disp_fase", 1);
        expectVal("disp_idle", 32'h40);
        #1;
        checkVal(32'(bus.FaseDisplay));
        tick(1);
        checkVal(32'(bus.Segmentos));

        // Round-robin: zones 1 and 3 drip (hot, humid air, tank at Medium).
        bus.UmidadeSolo = 4'b0101;
        bus.UmidadeAr   = 4'b1010;
        bus.Temperatura = 4'b1010;
        expectVal("rr_first", 4'b0010);
        expectVal("rr_zona1", 1);
        expectVal("rr_seg", 32'h3D);
        expectVal("rr_len1", 199);
        expectVal("rr_second", 4'b1000);
        expectVal("rr_zona3", 3);
        expectVal("rr_len3", 200);
        expectVal("rr_third", 4'b0010);
        expectVal("rr_zona1_again", 1);
        tick(3);
        checkVal(32'(bus.Gotejamento));
        checkVal(32'(bus.ZonaAtiva));
        tick(1);
        checkVal(32'(bus.Segmentos));
        measureHigh(1, 1'b0, len);
        checkVal(32'(len));
        tick(1);
        checkVal(32'(bus.Gotejamento));
        checkVal(32'(bus.ZonaAtiva));
        measureHigh(3, 1'b0, len);
        checkVal(32'(len));
        tick(1);
        checkVal(32'(bus.Gotejamento));
        checkVal(32'(bus.ZonaAtiva));

        // Hand over to zone 2, then reset mid-run.
        bus.UmidadeSolo = 4'b1011;
        bus.UmidadeAr   = 4'b0100;
        bus.Temperatura = 4'b0100;
        expectVal("mr_run", 4'b0100);
        tick(5);
        checkVal(32'(bus.Gotejamento));
        Reset_n = 1'b0;
        expectVal("mr_async_got", 0);
        expectVal("mr_async_zona", 0);
        expectVal("mr_async_seg", 0);
        #1;
        checkVal(32'(bus.Gotejamento));
        checkVal(32'(bus.ZonaAtiva));
        checkVal(32'(bus.Segmentos));
        tick(2);
        Reset_n         = 1'b1;
        bus.ModoDisplay = 1'b0;
        expectVal("mr_nogrant", 0);
        expectVal("mr_grant", 4'b0100);
        expectVal("mr_zona2", 2);
        tick(11);
        checkVal(32'(bus.Gotejamento));
        tick(1);
        checkVal(32'(bus.Gotejamento));
        checkVal(32'(bus.ZonaAtiva));

        // Automatic display phase toggles on the 1000th cycle after release.
        expectVal("auto_pre", 0);
        expectVal("auto_toggle", 1);
        tick(987);
        checkVal(32'(bus.FaseDisplay));
        tick(1);
        checkVal(32'(bus.FaseDisplay));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
